memoria32_data: RTL and testbench



---
 rtl/memoria32_data.sv | 66 ++++++
 tb/tb_memoria32_data.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/memoria32_data.sv
// Byte-addressed 32-bit data RAM: little-endian, unaligned access with wrap, registered read.
// Define MEMORIA32DATA_INIT_EN to preload contents from INIT_IMAGE (byte 0 in the low bits); otherwise all bytes start at zero.
module memoria32_data #(
    parameter int DEPTH_BYTES = 512,
    parameter int DATA_W      = 32,
    parameter logic [8*DEPTH_BYTES-1:0] INIT_IMAGE = '0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [31:0]       raddress,
    input  logic [31:0]       waddress,
    input  logic [DATA_W-1:0] Datain,
    input  logic              Wr,
    output logic [DATA_W-1:0] Dataout
);
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int LANES = DATA_W / 8;

    logic [7:0] mem [0:DEPTH_BYTES-1] = '{default: 8'h00};

`ifdef MEMORIA32DATA_INIT_EN
    initial begin
        for (int i = 0; i < DEPTH_BYTES; i++)
            mem[i] = INIT_IMAGE[8*i +: 8];
    end
`endif

    logic [AW-1:0]           ra;
    logic [AW-1:0]           wa;
    logic [LANES-1:0][AW-1:0] ridx;
    logic [LANES-1:0][AW-1:0] widx;
    logic [DATA_W-1:0]       rword;
    logic                    unused_addr_hi;

    assign ra = raddress[AW-1:0];
    assign wa = waddress[AW-1:0];
    // Upper address bits alias onto the same storage.
    assign unused_addr_hi = ^{raddress[31:AW], waddress[31:AW]};

    // Byte indices wrap naturally through AW-bit addition.
    always_comb begin
        ridx  = '0;
        widx  = '0;
        rword = '0;
        for (int i = 0; i < LANES; i++) begin
            ridx[i]          = ra + AW'(i);
            widx[i]          = wa + AW'(i);
            rword[8*i +: 8]  = mem[ridx[i]];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset_n && Wr) begin
            for (int i = 0; i < LANES; i++)
                mem[widx[i]] <= Datain[8*i +: 8];
        end
    end

    // Read samples pre-write contents, so same-edge collisions return old data.
    always_ff @(posedge Clk) begin
        if (!Reset_n)
            Dataout <= '0;
        else
            Dataout <= rword;
    end
endmodule

// File: tb/tb_memoria32_data.sv
// Directed self-checking bench for memoria32_data (default build, DEPTH_BYTES=512).
module tb_memoria32_data;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [31:0] raddress;
    logic [31:0] waddress;
    logic [31:0] Datain;
    logic        Wr;
    logic [31:0] Dataout;

    int total = 0;
    int bad   = 0;

    memoria32_data #(.DEPTH_BYTES(512), .DATA_W(32)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .raddress (raddress),
        .waddress (waddress),
        .Datain   (Datain),
        .Wr       (Wr),
        .Dataout  (Dataout)
    );

    always #5 Clk = ~Clk;

    // One rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic rst_n, input logic wr, input logic [31:0] wa,
                         input logic [31:0] din, input logic [31:0] ra);
        Reset_n  = rst_n;
        Wr       = wr;
        waddress = wa;
        Datain   = din;
        raddress = ra;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 32'd0, 32'hDEADBEEF, 32'd0);
        tick();
        total++;
        if (Dataout !== 32'h0) begin bad++; $display("FAIL reset_edge1 got=%h exp=%h", Dataout, 32'h0); end
        tick();
        total++;
        if (Dataout !== 32'h0) begin bad++; $display("FAIL reset_edge2 got=%h exp=%h", Dataout, 32'h0); end
        drive(1'b1, 1'b0, 32'd0, 32'h0, 32'd0);
        tick();
        total++;
        if (Dataout !== 32'h0) begin bad++; $display("FAIL reset_write_dropped got=%h exp=%h", Dataout, 32'h0); end
    endtask

    task automatic test_aligned();
        drive(1'b1, 1'b1, 32'd8, 32'h12345678, 32'd8);
        tick();
        total++;
        if (Dataout !== 32'h0) begin bad++; $display("FAIL aligned_pre got=%h exp=%h", Dataout, 32'h0); end
        drive(1'b1, 1'b0, 32'd0, 32'h0, 32'd8);
        tick();
        total++;
        if (Dataout !== 32'h12345678) begin bad++; $display("FAIL aligned_rd8 got=%h exp=%h", Dataout, 32'h12345678); end
        raddress = 32'd9;
        tick();
        total++;
        if (Dataout !== 32'h00123456) begin bad++; $display("FAIL unaligned_rd9 got=%h exp=%h", Dataout, 32'h00123456); end
        raddress = 32'd6;
        tick();
        total++;
        if (Dataout !== 32'h56780000) begin bad++; $display("FAIL unaligned_rd6 got=%h exp=%h", Dataout, 32'h56780000); end
    endtask

    task automatic test_collision();
        drive(1'b1, 1'b1, 32'd16, 32'hAAAA5555, 32'd16);
        tick();
        total++;
        if (Dataout !== 32'h0) begin bad++; $display("FAIL collide_old got=%h exp=%h", Dataout, 32'h0); end
        drive(1'b1, 1'b0, 32'd0, 32'h0, 32'd16);
        tick();
        total++;
        if (Dataout !== 32'hAAAA5555) begin bad++; $display("FAIL collide_new got=%h exp=%h", Dataout, 32'hAAAA5555); end
        // Partial overlap: bytes 18,19 shared between read and write.
        drive(1'b1, 1'b1, 32'd18, 32'h11223344, 32'd16);
        tick();
        total++;
        if (Dataout !== 32'hAAAA5555) begin bad++; $display("FAIL partial_old got=%h exp=%h", Dataout, 32'hAAAA5555); end
        drive(1'b1, 1'b0, 32'd0, 32'h0, 32'd16);
        tick();
        total++;
        if (Dataout !== 32'h33445555) begin bad++; $display("FAIL partial_new got=%h exp=%h", Dataout, 32'h33445555); end
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 32'd510, 32'hCAFEF00D, 32'd100);
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'h0, 32'd0);
        tick();
        total++;
        if (Dataout !== 32'h0000CAFE) begin bad++; $display("FAIL wrap_rd0 got=%h exp=%h", Dataout, 32'h0000CAFE); end
        raddress = 32'd510;
        tick();
        total++;
        if (Dataout !== 32'hCAFEF00D) begin bad++; $display("FAIL wrap_rd510 got=%h exp=%h", Dataout, 32'hCAFEF00D); end
        raddress = 32'd511;
        tick();
        total++;
        if (Dataout !== 32'h00CAFEF0) begin bad++; $display("FAIL wrap_rd511 got=%h exp=%h", Dataout, 32'h00CAFEF0); end
    endtask

    task automatic test_alias();
        drive(1'b1, 1'b1, 32'h0000_0204, 32'h0BADF00D, 32'd100);
        tick();
        drive(1'b1, 1'b0, 32'd0, 32'h0, 32'd4);
        tick();
        total++;
        if (Dataout !== 32'h0BADF00D) begin bad++; $display("FAIL alias_rd4 got=%h exp=%h", Dataout, 32'h0BADF00D); end
        raddress = 32'hFFFF_FE04;
        tick();
        total++;
        if (Dataout !== 32'h0BADF00D) begin bad++; $display("FAIL alias_rdhi got=%h exp=%h", Dataout, 32'h0BADF00D); end
    endtask

    task automatic test_midreset();
        drive(1'b0, 1'b1, 32'd40, 32'h55667788, 32'd8);
        tick();
        total++;
        if (Dataout !== 32'h0) begin bad++; $display("FAIL midreset_out got=%h exp=%h", Dataout, 32'h0); end
        drive(1'b1, 1'b0, 32'd0, 32'h0, 32'd40);
        tick();
        total++;
        if (Dataout !== 32'h0) begin bad++; $display("FAIL midreset_dropped got=%h exp=%h", Dataout, 32'h0); end
        raddress = 32'd8;
        tick();
        total++;
        if (Dataout !== 32'h12345678) begin bad++; $display("FAIL midreset_retained got=%h exp=%h", Dataout, 32'h12345678); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 32'd64, 32'hA1A1A1A1, 32'd64);
        tick();
        total++;
        if (Dataout !== 32'h0) begin bad++; $display("FAIL b2b_0 got=%h exp=%h", Dataout, 32'h0); end
        drive(1'b1, 1'b1, 32'd68, 32'hB2B2B2B2, 32'd64);
        tick();
        total++;
        if (Dataout !== 32'hA1A1A1A1) begin bad++; $display("FAIL b2b_1 got=%h exp=%h", Dataout, 32'hA1A1A1A1); end
        drive(1'b1, 1'b1, 32'd72, 32'hC3C3C3C3, 32'd68);
        tick();
        total++;
        if (Dataout !== 32'hB2B2B2B2) begin bad++; $display("FAIL b2b_2 got=%h exp=%h", Dataout, 32'hB2B2B2B2); end
        drive(1'b1, 1'b0, 32'd0, 32'h0, 32'd72);
        tick();
        total++;
        if (Dataout !== 32'hC3C3C3C3) begin bad++; $display("FAIL b2b_3 got=%h exp=%h", Dataout, 32'hC3C3C3C3); end
    endtask

    initial begin
        drive(1'b0, 1'b1, 32'd0, 32'hDEADBEEF, 32'd0);
        #2;
        test_reset();
        test_aligned();
        test_collision();
        test_wrap();
        test_alias();
        test_midreset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
